// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register-file defaults, clear-FSM state encoding
// and the hardwired zero-register address.
package mips_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int ZERO_ADDR = 0;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_rd_mux.sv
// One combinational read port of the register file.
// Priority: clear gating, then the zero register, then write bypass, then storage.
module regfile_rd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clearing,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] rdata
);

    always_comb begin
        rdata = mem_data;
        if (clearing) begin
            rdata = '0;
        end else if ((ZERO_REG != 0) && (raddr == ADDR_W'(ZERO_ADDR))) begin
            rdata = '0;
        end else if ((BYPASS != 0) && we && (waddr == raddr)) begin
            rdata = wdata;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: flop-array storage, NUM_RD combinational read ports,
// single write port and a sequencer that zeroes the whole bank after reset or on request.
//
//   state    | meaning
//   RF_CLEAR | zeroing entry clr_cnt each cycle; reads return 0, writes dropped
//   RF_READY | normal operation; clr_req restarts the clear
module regfile_param
    import mips_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     clr_req,
    output logic                     ready
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    rf_state_e         state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              clearing;
    logic              wr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RF_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            RF_CLEAR: begin
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == {ADDR_W{1'b1}}) begin
                    state_nxt = RF_READY;
                end
            end
            RF_READY: begin
                if (clr_req) begin
                    state_nxt   = RF_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = RF_CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    assign clearing = (state == RF_CLEAR);
    assign ready    = (state == RF_READY);

    // A write in the clr_req cycle still lands; the clear erases it afterwards.
    assign wr_en = !reset && (state == RF_READY) && we &&
                   !((ZERO_REG != 0) && (waddr == ADDR_W'(ZERO_ADDR)));

    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] port_addr;

        assign port_addr = raddr[k*ADDR_W +: ADDR_W];

        regfile_rd_mux #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .BYPASS  (BYPASS),
            .ZERO_REG(ZERO_REG)
        ) u_rd_mux (
            .clearing(clearing),
            .we      (we),
            .waddr   (waddr),
            .wdata   (wdata),
            .raddr   (port_addr),
            .mem_data(mem[port_addr]),
            .rdata   (rdata[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: one bank with bypass, one without, sharing stimulus.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic        clr_req;
    logic [63:0] rdata_b, rdata_n;
    logic        ready_b, ready_n;

    int n_cmp = 0;
    int n_mis = 0;
    int cnt;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_byp (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .clr_req(clr_req), .ready(ready_b)
    );

    regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_nbp (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .clr_req(clr_req), .ready(ready_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    // Counts edges until ready rises; optionally pulses clr_req mid-clear.
    task automatic wait_ready(input int pulse_at, output int n);
        n = 0;
        while (ready_b !== 1'b1 && n < 100) begin
            clr_req = (n == pulse_at);
            @(posedge clk); #1;
            n++;
        end
        clr_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(a), 5'(a)};
            #1;
            chk({tag, "_b0"}, rdata_b[31:0], 32'h0);
            chk({tag, "_n1"}, rdata_n[63:32], 32'h0);
        end
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; clr_req = 1'b0;

        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_ready_b", 32'(ready_b), 32'h0);
        chk("rst_ready_n", 32'(ready_n), 32'h0);
        raddr = {5'd3, 5'd1};
        #1;
        chk("rst_rdata_b", rdata_b[31:0], 32'h0);
        wait_ready(-1, cnt);
        chk("rst_clear_cycles", 32'(cnt), 32'd32);
        chk("rst_ready_n_up", 32'(ready_n), 32'h1);
        chk_all_zero("rst_zero");

        wr(5'd5, 32'hDEADBEEF);
        raddr = {5'd5, 5'd5};
        #1;
        chk("wr_r5_b0", rdata_b[31:0], 32'hDEADBEEF);
        chk("wr_r5_b1", rdata_b[63:32], 32'hDEADBEEF);
        chk("wr_r5_n0", rdata_n[31:0], 32'hDEADBEEF);
        chk("wr_r5_n1", rdata_n[63:32], 32'hDEADBEEF);

        wr(5'd0, 32'h12345678);
        raddr = 10'd0;
        #1;
        chk("zero_b0", rdata_b[31:0], 32'h0);
        chk("zero_b1", rdata_b[63:32], 32'h0);
        chk("zero_n0", rdata_n[31:0], 32'h0);
        chk("zero_n1", rdata_n[63:32], 32'h0);

        we = 1'b1; waddr = 5'd0; wdata = 32'h55AA55AA; raddr = 10'd0;
        #1;
        chk("zero_bypass_b0", rdata_b[31:0], 32'h0);
        @(posedge clk); #1;
        we = 1'b0;

        we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5; raddr = {5'd9, 5'd5};
        #1;
        chk("bypass_b1", rdata_b[63:32], 32'hA5A5A5A5);
        chk("nobypass_n1", rdata_n[63:32], 32'h0);
        chk("bypass_other_port", rdata_b[31:0], 32'hDEADBEEF);
        @(posedge clk); #1;
        we = 1'b0;
        #1;
        chk("nobypass_next_n1", rdata_n[63:32], 32'hA5A5A5A5);
        chk("bypass_next_b1", rdata_b[63:32], 32'hA5A5A5A5);

        we = 1'b1; waddr = 5'd12; wdata = 32'h1;
        @(posedge clk); #1;
        wdata = 32'h2;
        @(posedge clk); #1;
        we = 1'b0; raddr = {5'd12, 5'd12};
        #1;
        chk("b2b_last_b", rdata_b[31:0], 32'h2);
        chk("b2b_last_n", rdata_n[63:32], 32'h2);

        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
        raddr = {5'd31, 5'd17};
        #1;
        chk("fill_r17", rdata_b[31:0], 32'd17);
        chk("fill_r31", rdata_n[63:32], 32'd31);

        clr_req = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        clr_req = 1'b0; waddr = 5'd7; wdata = 32'h77;
        raddr = {5'd3, 5'd1};
        #1;
        chk("clr_ready_lo", 32'(ready_b), 32'h0);
        chk("clr_rd_gated", rdata_b[31:0], 32'h0);
        wait_ready(5, cnt);
        we = 1'b0;
        chk("clr_cycles", 32'(cnt), 32'd32);
        chk_all_zero("clr_zero");

        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i + 100));
        raddr = {5'd20, 5'd20};
        #1;
        chk("refill_r20", rdata_b[31:0], 32'd120);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("mid_ready_lo", 32'(ready_b), 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        wait_ready(-1, cnt);
        chk("mid_rst_cycles", 32'(cnt), 32'd32);
        chk("mid_ready_n", 32'(ready_n), 32'h1);
        chk_all_zero("mid_zero");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
